// File: rtl/decode_queue_if.sv
// Fetch-to-execute bundle for decode_queue: fetch handshake, flush, live flags
// and the decoded head record handed to execute.
interface decode_queue_if #(
  parameter int CODE_W = 11,
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic              flush;
  logic [3:0]        flags;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_rd;
  logic [3:0]        out_rn;
  logic [3:0]        out_rm;
  logic [7:0]        out_shift;
  logic [31:0]       out_imm32;
  logic              out_imm_en;
  logic              out_set_flags;
  logic              out_mem_up;
  logic [ADDR_W-1:0] out_br_target;
  logic [CODE_W-1:0] out_alu_code;
  logic              out_execute;
  logic              out_undef;
  logic [ADDR_W-1:0] out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, flags, out_ready,
    output in_ready, out_valid, out_rd, out_rn, out_rm, out_shift, out_imm32,
           out_imm_en, out_set_flags, out_mem_up, out_br_target, out_alu_code,
           out_execute, out_undef, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, flags, out_ready,
    input  in_ready, out_valid, out_rd, out_rn, out_rm, out_shift, out_imm32,
           out_imm_en, out_set_flags, out_mem_up, out_br_target, out_alu_code,
           out_execute, out_undef, out_pc
  );
endinterface

// File: rtl/decode_queue.sv
// ARM decode stage: decodes at entry, buffers in an in-order circular queue and
// evaluates the head's condition against live NZCV flags.
module decode_queue #(
  parameter int DEPTH  = 2,
  parameter int CODE_W = 11,
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           reset,
  decode_queue_if.slave q
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]        cond;
    logic [3:0]        rd;
    logic [3:0]        rn;
    logic [3:0]        rm;
    logic [7:0]        shift;
    logic [31:0]       imm32;
    logic              imm_en;
    logic              set_flags;
    logic              mem_up;
    logic [ADDR_W-1:0] br_target;
    logic [CODE_W-1:0] alu_code;
    logic              undef;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  function automatic logic [5:0] dp_code(input logic [3:0] opcode);
    case (opcode)
      4'h0:    dp_code = 6'd3;   // AND
      4'h1:    dp_code = 6'd5;   // EOR
      4'h2:    dp_code = 6'd2;   // SUB
      4'h3:    dp_code = 6'd1;   // RSB
      4'h4:    dp_code = 6'd0;   // ADD
      4'h5:    dp_code = 6'd14;  // ADC
      4'h6:    dp_code = 6'd15;  // SBC
      4'h7:    dp_code = 6'd16;  // RSC
      4'h8:    dp_code = 6'd9;   // TST
      4'h9:    dp_code = 6'd10;  // TEQ
      4'hA:    dp_code = 6'd8;   // CMP
      4'hB:    dp_code = 6'd12;  // CMN
      4'hC:    dp_code = 6'd4;   // ORR
      4'hD:    dp_code = 6'd6;   // MOV
      4'hE:    dp_code = 6'd11;  // BIC
      default: dp_code = 6'd7;   // MVN
    endcase
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  entry_t            dec_entry;
  logic [31:0]       imm8;
  logic [4:0]        rot;
  logic [33:0]       br_off;
  logic [31:0]       instr;

  // NOTE: every field gets a default before the branches so no latch is inferred.
  always_comb begin
    instr     = q.in_instr;
    imm8      = {24'b0, instr[7:0]};
    rot       = {instr[11:8], 1'b0};
    br_off    = {{8{instr[23]}}, instr[23:0], 2'b00};
    dec_entry = '0;
    dec_entry.cond = instr[31:28];
    dec_entry.pc   = q.in_pc;
    if (instr[27:26] == 2'b00) begin
      dec_entry.rd        = instr[15:12];
      dec_entry.rn        = instr[19:16];
      dec_entry.rm        = instr[3:0];
      dec_entry.shift     = instr[11:4];
      dec_entry.set_flags = instr[20];
      dec_entry.alu_code  = CODE_W'(dp_code(instr[24:21]));
      if (instr[25]) begin
        dec_entry.imm_en = 1'b1;
        dec_entry.imm32  = (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot}));
      end
      // Compare-class opcodes exist only to set flags; without S they are not valid.
      if (instr[24:23] == 2'b10 && !instr[20]) begin
        dec_entry.undef    = 1'b1;
        dec_entry.alu_code = '1;
      end
    end else if (instr[27:25] == 3'b101) begin
      dec_entry.alu_code  = instr[24] ? CODE_W'(32) : CODE_W'(31);
      dec_entry.br_target = q.in_pc + ADDR_W'(32'd8) + ADDR_W'($signed(br_off));
    end else if (instr[27:26] == 2'b01) begin
      dec_entry.rn       = instr[19:16];
      dec_entry.shift    = instr[11:4];
      dec_entry.mem_up   = instr[23];
      dec_entry.alu_code = instr[20] ? CODE_W'(41) : CODE_W'(42);
      if (instr[20]) begin
        dec_entry.rd = instr[15:12];
        dec_entry.rm = instr[25] ? instr[3:0] : 4'h0;
      end else begin
        dec_entry.rm = instr[15:12];
      end
      if (!instr[25]) begin
        dec_entry.imm_en = 1'b1;
        dec_entry.imm32  = {20'b0, instr[11:0]};
      end
    end else begin
      dec_entry.undef    = 1'b1;
      dec_entry.alu_code = '1;
    end
  end

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready, out_valid, push, pop;

  assign in_ready  = (count_q < CNT_W'(DEPTH)) & ~q.flush & ~reset;
  assign out_valid = (count_q != '0);
  assign push      = q.in_valid & in_ready;
  assign pop       = out_valid & q.out_ready & ~q.flush;

  always_comb begin
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; count gates visibility, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_entry;
  end

  entry_t head;
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign q.in_ready      = in_ready;
  assign q.out_valid     = out_valid;
  assign q.out_rd        = head.rd;
  assign q.out_rn        = head.rn;
  assign q.out_rm        = head.rm;
  assign q.out_shift     = head.shift;
  assign q.out_imm32     = head.imm32;
  assign q.out_imm_en    = head.imm_en;
  assign q.out_set_flags = head.set_flags;
  assign q.out_mem_up    = head.mem_up;
  assign q.out_br_target = head.br_target;
  assign q.out_alu_code  = head.alu_code;
  assign q.out_undef     = head.undef;
  assign q.out_pc        = head.pc;
  assign q.out_execute   = out_valid & cond_pass(head.cond, q.flags);
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: table of decode vectors plus hand-written
// condition, backpressure, flush and reset sequences.
module tb_decode_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_queue_if #(.CODE_W(11), .ADDR_W(32)) bus ();

  decode_queue #(.DEPTH(2), .CODE_W(11), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic [10:0] code;
    logic [3:0]  rd, rn, rm;
    logic [7:0]  shift;
    logic [31:0] imm;
    logic        imm_en, sf, up;
    logic [31:0] br;
    logic        exe, undef;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{32'hE0875006, 32'h0,   4'b0000, 11'd0,   4'd5, 4'd7, 4'd6, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[1]  = '{32'hE3A004FF, 32'h0,   4'b0000, 11'd6,   4'd0, 4'd0, 4'hF, 8'h4F, 32'hFF000000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[2]  = '{32'hEAFFFFFE, 32'h100, 4'b0000, 11'd31,  4'd0, 4'd0, 4'd0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h100,      1'b1, 1'b0};
    vecs[3]  = '{32'hEB000001, 32'h200, 4'b0000, 11'd32,  4'd0, 4'd0, 4'd0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h20C,      1'b1, 1'b0};
    vecs[4]  = '{32'hEAFFFFFD, 32'h0,   4'b0000, 11'd31,  4'd0, 4'd0, 4'd0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0};
    vecs[5]  = '{32'hE5921004, 32'h0,   4'b0000, 11'd41,  4'd1, 4'd2, 4'd0, 8'h00, 32'h4,        1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[6]  = '{32'hE5823008, 32'h0,   4'b0000, 11'd42,  4'd0, 4'd2, 4'd3, 8'h00, 32'h8,        1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[7]  = '{32'hE1000000, 32'h0,   4'b0000, 11'h7FF, 4'd0, 4'd0, 4'd0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[8]  = '{32'h02912103, 32'h0,   4'b0100, 11'd0,   4'd2, 4'd1, 4'd3, 8'h10, 32'hC0000000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{32'hE1510002, 32'h0,   4'b0000, 11'd8,   4'd0, 4'd1, 4'd2, 8'h00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{32'h41E00001, 32'h0,   4'b1000, 11'd7,   4'd0, 4'd0, 4'd1, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[11] = '{32'hF1E00001, 32'h0,   4'b1111, 11'd7,   4'd0, 4'd0, 4'd1, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[12] = '{32'hC1E00001, 32'h0,   4'b1001, 11'd7,   4'd0, 4'd0, 4'd1, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[13] = '{32'hB1E00001, 32'h0,   4'b1001, 11'd7,   4'd0, 4'd0, 4'd1, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[14] = '{32'hE7921003, 32'h0,   4'b0000, 11'd41,  4'd1, 4'd2, 4'd3, 8'h00, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.flags     = 4'b0000;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;
    #1;
    check("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    check("post-reset out_pc", 64'(bus.out_pc), 64'd0);
    tick();

    // Decode table: push one entry, inspect the head, pop it.
    for (int i = 0; i < 15; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_instr  = vecs[i].instr;
      bus.in_pc     = vecs[i].pc;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      bus.flags    = vecs[i].flags;
      #1;
      check($sformatf("v%0d valid", i),     64'(bus.out_valid),     64'd1);
      check($sformatf("v%0d code", i),      64'(bus.out_alu_code),  64'(vecs[i].code));
      check($sformatf("v%0d rd", i),        64'(bus.out_rd),        64'(vecs[i].rd));
      check($sformatf("v%0d rn", i),        64'(bus.out_rn),        64'(vecs[i].rn));
      check($sformatf("v%0d rm", i),        64'(bus.out_rm),        64'(vecs[i].rm));
      check($sformatf("v%0d shift", i),     64'(bus.out_shift),     64'(vecs[i].shift));
      check($sformatf("v%0d imm32", i),     64'(bus.out_imm32),     64'(vecs[i].imm));
      check($sformatf("v%0d imm_en", i),    64'(bus.out_imm_en),    64'(vecs[i].imm_en));
      check($sformatf("v%0d set_flags", i), 64'(bus.out_set_flags), 64'(vecs[i].sf));
      check($sformatf("v%0d mem_up", i),    64'(bus.out_mem_up),    64'(vecs[i].up));
      check($sformatf("v%0d br_target", i), 64'(bus.out_br_target), 64'(vecs[i].br));
      check($sformatf("v%0d execute", i),   64'(bus.out_execute),   64'(vecs[i].exe));
      check($sformatf("v%0d undef", i),     64'(bus.out_undef),     64'(vecs[i].undef));
      check($sformatf("v%0d pc", i),        64'(bus.out_pc),        64'(vecs[i].pc));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      #1;
      check($sformatf("v%0d drained", i), 64'(bus.out_valid), 64'd0);
    end

    // Condition follows live flags with the head held.
    bus.flags    = 4'b0000;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0A000001;
    bus.in_pc    = 32'h0;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("beq z=0 execute", 64'(bus.out_execute), 64'd0);
    check("beq target", 64'(bus.out_br_target), 64'hC);
    bus.flags = 4'b0100;
    #1;
    check("beq z=1 execute", 64'(bus.out_execute), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h9A000001;
    tick();
    bus.in_valid = 1'b0;
    bus.flags    = 4'b0011;
    #1;
    check("bls c=1 z=0 execute", 64'(bus.out_execute), 64'd0);
    bus.flags = 4'b0110;
    #1;
    check("bls z=1 execute", 64'(bus.out_execute), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Backpressure: third push is held until space frees; ordered drain.
    bus.flags    = 4'b0000;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hE0800000;
    bus.in_pc    = 32'h10;
    #1;
    check("bp ready 0", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_pc = 32'h20;
    #1;
    check("bp ready 1", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_pc = 32'h30;
    #1;
    check("bp full ready", 64'(bus.in_ready), 64'd0);
    check("bp head A", 64'(bus.out_pc), 64'h10);
    tick();
    #1;
    check("bp held ready", 64'(bus.in_ready), 64'd0);
    check("bp held head", 64'(bus.out_pc), 64'h10);
    bus.out_ready = 1'b1;
    #1;
    check("bp no push when full", 64'(bus.in_ready), 64'd0);
    tick();
    #1;
    check("bp head B", 64'(bus.out_pc), 64'h20);
    check("bp ready after pop", 64'(bus.in_ready), 64'd1);
    tick();
    #1;
    check("bp push+pop valid", 64'(bus.out_valid), 64'd1);
    check("bp push+pop head C", 64'(bus.out_pc), 64'h30);
    check("bp push+pop ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
    tick();
    #1;
    check("bp drained", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Flush at count 2 with a concurrent input.
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h40;
    tick();
    bus.in_pc = 32'h50;
    tick();
    #1;
    check("fl full valid", 64'(bus.out_valid), 64'd1);
    bus.in_pc = 32'h60;
    bus.flush = 1'b1;
    #1;
    check("fl in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("fl out_valid", 64'(bus.out_valid), 64'd0);
    check("fl ready after", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h70;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("fl fresh head", 64'(bus.out_pc), 64'h70);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset mid-stream with one entry queued.
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hE3A004FF;
    bus.in_pc    = 32'h80;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("rs queued valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("rs in_ready low", 64'(bus.in_ready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rs out_valid", 64'(bus.out_valid), 64'd0);
    check("rs out_pc", 64'(bus.out_pc), 64'd0);
    check("rs out_imm32", 64'(bus.out_imm32), 64'd0);
    check("rs out_alu_code", 64'(bus.out_alu_code), 64'd0);
    check("rs out_imm_en", 64'(bus.out_imm_en), 64'd0);
    check("rs out_execute", 64'(bus.out_execute), 64'd0);
    check("rs in_ready", 64'(bus.in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
